uart_rx_collector: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_collector_if.sv | 36 +++
 rtl/uart_rx_timeout.sv | 50 +++++
 rtl/uart_rx_collector.sv | 149 ++++++++++++++
 tb/tb_uart_rx_collector.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants.
package uart_pkg;

    localparam int unsigned UART_BYTE_W             = 8;
    localparam int unsigned UART_RX_TIMEOUT_DEFAULT = 640;

    typedef enum logic {
        IDLE  = 1'b0,
        LATCH = 1'b1
    } rx_collect_state_t;

endpackage

// File: rtl/uart_rx_collector_if.sv
// Bus bundle between the UART receiver, the collector and the register front-end.
interface uart_rx_collector_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                   rxEn;
    logic [UART_BYTE_W-1:0] rxData;
    logic                   rxDone;
    logic                   rxErr;
    logic                   pop;
    logic                   clear;
    logic                   errClear;
    logic [CW-1:0]          threshold;
    logic [UART_BYTE_W-1:0] rdata;
    logic                   rdValid;
    logic [CW-1:0]          count;
    logic                   frameErr;
    logic                   overrun;
    logic [7:0]             errCount;
    logic                   timeout;
    logic                   irq;

    modport master (
        output rxEn, rxData, rxDone, rxErr, pop, clear, errClear, threshold,
        input  rdata, rdValid, count, frameErr, overrun, errCount, timeout, irq
    );

    modport slave (
        input  rxEn, rxData, rxDone, rxErr, pop, clear, errClear, threshold,
        output rdata, rdValid, count, frameErr, overrun, errCount, timeout, irq
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Receive-idle timer: counts oversample ticks while data waits unread, flags at the limit.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = UART_RX_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic nReset,
    input  logic rx_en_i,
    input  logic active_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic clear_i,
    output logic timeout_o
);
    localparam int unsigned   TW    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clear_i || push_i || pop_i) begin
            cnt_d = '0;
        end else if (active_i && rx_en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TW'(1);
        end
        if (cnt_d == LIMIT) begin
            timeout_d = 1'b1;
        end
        if (clear_i || pop_i) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/uart_rx_collector.sv
// Receive byte collector: capture FSM, power-of-2 FIFO, sticky errors, irq.
// Optional idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_collector
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned TIMEOUT_TICKS = UART_RX_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                nReset,
    uart_rx_collector_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_TICKS == 0)) begin : g_bad_param
        $error("uart_rx_collector: DEPTH must be a power of 2 >= 2 and TIMEOUT_TICKS nonzero");
    end

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [UART_BYTE_W-1:0] rdata_q, rdata_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   rx_done_q;
    rx_collect_state_t      state_q, state_d;

    logic       latch_c, full_c, pop_fire_c, push_fire_c, drop_c, timeout_c;
    logic [8:0] err_sum_c;

    // Capture FSM: one LATCH cycle per rising edge of rxDone.
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        case (state_q)
            IDLE:    if (bus.rxDone && !rx_done_q) state_d = LATCH;
            LATCH: begin
                latch_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.clear) begin
            state_d = IDLE;
            latch_c = 1'b0;
        end
    end

    assign full_c      = (count_q == CW'(DEPTH));
    assign pop_fire_c  = bus.pop && rd_valid_q;
    assign push_fire_c = latch_c && (!full_c || pop_fire_c);
    assign drop_c      = latch_c && full_c && !pop_fire_c;
    assign err_sum_c   = {1'b0, err_count_q} + 9'(bus.rxErr) + 9'(drop_c);

    // FIFO bookkeeping and error tracking; rdata follows the head with hold-on-empty.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push_fire_c);
        rd_ptr_d    = rd_ptr_q + AW'(pop_fire_c);
        count_d     = count_q + CW'(push_fire_c) - CW'(pop_fire_c);
        rdata_d     = rdata_q;
        if (pop_fire_c && (count_q > CW'(1))) begin
            rdata_d = mem_q[rd_ptr_d];
        end else if (push_fire_c && ((count_q == '0) || pop_fire_c)) begin
            rdata_d = bus.rxData;
        end
        rd_valid_d  = (count_d != '0);
        frame_err_d = frame_err_q | bus.rxErr;
        overrun_d   = overrun_q | drop_c;
        err_count_d = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
        if (bus.errClear) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
            err_count_d = '0;
        end
        if (bus.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rdata_d     = '0;
            rd_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            rx_done_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rx_done_q   <= bus.rxDone;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire_c) mem_q[wr_ptr_q] <= bus.rxData;
    end

`ifdef UART_RX_TIMEOUT_EN
    uart_rx_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk       (clk),
        .nReset    (nReset),
        .rx_en_i   (bus.rxEn),
        .active_i  (rd_valid_q),
        .push_i    (push_fire_c),
        .pop_i     (pop_fire_c),
        .clear_i   (bus.clear),
        .timeout_o (timeout_c)
    );
`else
    logic unused_rx_en_c;
    assign unused_rx_en_c = bus.rxEn;
    assign timeout_c      = 1'b0;
`endif

    assign bus.rdata    = rdata_q;
    assign bus.rdValid  = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.frameErr = frame_err_q;
    assign bus.overrun  = overrun_q;
    assign bus.errCount = err_count_q;
    assign bus.timeout  = timeout_c;
    assign bus.irq      = ((bus.threshold != '0) && (count_q >= bus.threshold))
                        | frame_err_q | overrun_q | timeout_c;

endmodule

// File: tb/tb_uart_rx_collector.sv
// Directed self-checking bench for uart_rx_collector (DEPTH=8, TIMEOUT_TICKS=640).
module tb_uart_rx_collector;
    import uart_pkg::*;

    logic clk;
    logic nReset;
    int   vecs;
    int   miscompares;

    uart_rx_collector_if #(.DEPTH(8)) bus ();

    uart_rx_collector #(.DEPTH(8), .TIMEOUT_TICKS(640)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rxDone pulse, byte on rxData the next cycle; returns two cycles later (count updated)
    task automatic push_byte(input logic [7:0] b, input logic pop_in_latch, input logic err_in_latch);
        bus.rxDone = 1'b1;
        tick();
        bus.rxDone = 1'b0;
        bus.rxData = b;
        bus.pop    = pop_in_latch;
        bus.rxErr  = err_in_latch;
        tick();
        bus.pop    = 1'b0;
        bus.rxErr  = 1'b0;
    endtask

    task automatic do_pop();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        vecs++; if (bus.rdata    !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
        vecs++; if (bus.rdValid  !== 1'b0)  begin miscompares++; $display("FAIL reset_rdValid got %b exp 0", bus.rdValid); end
        vecs++; if (bus.count    !== 4'd0)  begin miscompares++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        vecs++; if (bus.frameErr !== 1'b0)  begin miscompares++; $display("FAIL reset_frameErr got %b exp 0", bus.frameErr); end
        vecs++; if (bus.overrun  !== 1'b0)  begin miscompares++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        vecs++; if (bus.errCount !== 8'd0)  begin miscompares++; $display("FAIL reset_errCount got %0d exp 0", bus.errCount); end
        vecs++; if (bus.timeout  !== 1'b0)  begin miscompares++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
        vecs++; if (bus.irq      !== 1'b0)  begin miscompares++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
    endtask

    task automatic test_single();
        bus.rxDone = 1'b1;
        tick();
        bus.rxDone = 1'b0;
        bus.rxData = 8'hA5;
        vecs++; if (bus.rdValid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b exp 0", bus.rdValid); end
        tick();
        vecs++; if (bus.rdValid !== 1'b1)  begin miscompares++; $display("FAIL single_valid got %b exp 1", bus.rdValid); end
        vecs++; if (bus.rdata   !== 8'hA5) begin miscompares++; $display("FAIL single_rdata got %h exp a5", bus.rdata); end
        vecs++; if (bus.count   !== 4'd1)  begin miscompares++; $display("FAIL single_count got %0d exp 1", bus.count); end
        do_pop();
        vecs++; if (bus.count   !== 4'd0)  begin miscompares++; $display("FAIL single_pop_count got %0d exp 0", bus.count); end
        vecs++; if (bus.rdValid !== 1'b0)  begin miscompares++; $display("FAIL single_pop_valid got %b exp 0", bus.rdValid); end
        do_pop();
        vecs++; if (bus.count   !== 4'd0)  begin miscompares++; $display("FAIL empty_pop_count got %0d exp 0", bus.count); end
        vecs++; if (bus.rdata   !== 8'hA5) begin miscompares++; $display("FAIL empty_pop_rdata got %h exp a5", bus.rdata); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) push_byte(8'(i), 1'b0, 1'b0);
        vecs++; if (bus.count    !== 4'd8) begin miscompares++; $display("FAIL ovr_count got %0d exp 8", bus.count); end
        vecs++; if (bus.overrun  !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b exp 1", bus.overrun); end
        vecs++; if (bus.errCount !== 8'd1) begin miscompares++; $display("FAIL ovr_errCount got %0d exp 1", bus.errCount); end
        vecs++; if (bus.irq      !== 1'b1) begin miscompares++; $display("FAIL ovr_irq got %b exp 1", bus.irq); end
        for (int i = 0; i < 8; i++) begin
            vecs++; if (bus.rdata !== 8'(i)) begin miscompares++; $display("FAIL ovr_order[%0d] got %h exp %h", i, bus.rdata, 8'(i)); end
            do_pop();
        end
        vecs++; if (bus.rdValid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain_valid got %b exp 0", bus.rdValid); end
        do_clear();
        vecs++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL clear_overrun got %b exp 0", bus.overrun); end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        push_byte(8'h18, 1'b1, 1'b0);
        vecs++; if (bus.count   !== 4'd8)  begin miscompares++; $display("FAIL fpp_count got %0d exp 8", bus.count); end
        vecs++; if (bus.overrun !== 1'b0)  begin miscompares++; $display("FAIL fpp_overrun got %b exp 0", bus.overrun); end
        vecs++; if (bus.rdata   !== 8'h11) begin miscompares++; $display("FAIL fpp_head got %h exp 11", bus.rdata); end
        for (int i = 1; i < 9; i++) begin
            vecs++; if (bus.rdata !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL fpp_order[%0d] got %h exp %h", i, bus.rdata, 8'h10 + 8'(i)); end
            do_pop();
        end
        // pop and push together on an empty FIFO: pop ignored, byte lands at head
        push_byte(8'h5C, 1'b1, 1'b0);
        vecs++; if (bus.count !== 4'd1)  begin miscompares++; $display("FAIL epp_count got %0d exp 1", bus.count); end
        vecs++; if (bus.rdata !== 8'h5C) begin miscompares++; $display("FAIL epp_rdata got %h exp 5c", bus.rdata); end
        do_clear();
    endtask

    task automatic test_errors();
        push_byte(8'h31, 1'b0, 1'b0);
        push_byte(8'h32, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.rxErr = 1'b1; tick(); bus.rxErr = 1'b0; tick();
        end
        vecs++; if (bus.frameErr !== 1'b1) begin miscompares++; $display("FAIL err_frame got %b exp 1", bus.frameErr); end
        vecs++; if (bus.errCount !== 8'd3) begin miscompares++; $display("FAIL err_count got %0d exp 3", bus.errCount); end
        vecs++; if (bus.irq      !== 1'b1) begin miscompares++; $display("FAIL err_irq got %b exp 1", bus.irq); end
        bus.errClear = 1'b1; tick(); bus.errClear = 1'b0;
        vecs++; if (bus.frameErr !== 1'b0)  begin miscompares++; $display("FAIL errclr_frame got %b exp 0", bus.frameErr); end
        vecs++; if (bus.errCount !== 8'd0)  begin miscompares++; $display("FAIL errclr_count got %0d exp 0", bus.errCount); end
        vecs++; if (bus.irq      !== 1'b0)  begin miscompares++; $display("FAIL errclr_irq got %b exp 0", bus.irq); end
        vecs++; if (bus.count    !== 4'd2)  begin miscompares++; $display("FAIL errclr_fifo_count got %0d exp 2", bus.count); end
        vecs++; if (bus.rdata    !== 8'h31) begin miscompares++; $display("FAIL errclr_rdata got %h exp 31", bus.rdata); end
        bus.rxErr = 1'b1;
        repeat (300) tick();
        bus.rxErr = 1'b0;
        vecs++; if (bus.errCount !== 8'd255) begin miscompares++; $display("FAIL err_saturate got %0d exp 255", bus.errCount); end
        do_clear();
        vecs++; if (bus.count    !== 4'd0) begin miscompares++; $display("FAIL clear_count got %0d exp 0", bus.count); end
        vecs++; if (bus.errCount !== 8'd0) begin miscompares++; $display("FAIL clear_errCount got %0d exp 0", bus.errCount); end
    endtask

    task automatic test_dual_event();
        for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i), 1'b0, 1'b0);
        push_byte(8'h48, 1'b0, 1'b1);
        vecs++; if (bus.errCount !== 8'd2) begin miscompares++; $display("FAIL dual_errCount got %0d exp 2", bus.errCount); end
        vecs++; if (bus.overrun  !== 1'b1) begin miscompares++; $display("FAIL dual_overrun got %b exp 1", bus.overrun); end
        vecs++; if (bus.frameErr !== 1'b1) begin miscompares++; $display("FAIL dual_frame got %b exp 1", bus.frameErr); end
        do_clear();
    endtask

    task automatic test_threshold();
        bus.threshold = 4'd4;
        for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i), 1'b0, 1'b0);
        vecs++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL thr_below got %b exp 0", bus.irq); end
        push_byte(8'h63, 1'b0, 1'b0);
        vecs++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL thr_at got %b exp 1", bus.irq); end
        do_pop();
        vecs++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL thr_after_pop got %b exp 0", bus.irq); end
        bus.threshold = 4'd0;
        do_clear();
    endtask

    task automatic test_timeout();
        logic exp_to;
`ifdef UART_RX_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        push_byte(8'h77, 1'b0, 1'b0);
        bus.rxEn = 1'b1;
        repeat (639) tick();
        vecs++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL to_639 got %b exp 0", bus.timeout); end
        tick();
        bus.rxEn = 1'b0;
        vecs++; if (bus.timeout !== exp_to) begin miscompares++; $display("FAIL to_640 got %b exp %b", bus.timeout, exp_to); end
        vecs++; if (bus.irq     !== exp_to) begin miscompares++; $display("FAIL to_irq got %b exp %b", bus.irq, exp_to); end
        do_pop();
        vecs++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL to_pop got %b exp 0", bus.timeout); end
    endtask

    task automatic test_reset_mid();
        push_byte(8'h99, 1'b0, 1'b0);
        bus.rxErr = 1'b1; tick(); bus.rxErr = 1'b0;
        bus.rxDone = 1'b1;
        tick();
        bus.rxDone = 1'b0;
        bus.rxData = 8'hEE;
        nReset = 1'b0;
        #1;
        test_reset();
        tick();
        nReset = 1'b1;
        tick();
        vecs++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL mid_reset_lost_byte got %0d exp 0", bus.count); end
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        nReset        = 1'b0;
        bus.rxEn      = 1'b0;
        bus.rxData    = 8'h00;
        bus.rxDone    = 1'b0;
        bus.rxErr     = 1'b0;
        bus.pop       = 1'b0;
        bus.clear     = 1'b0;
        bus.errClear  = 1'b0;
        bus.threshold = 4'd0;
        repeat (2) tick();
        test_reset();
        nReset = 1'b1;
        tick();
        test_single();
        test_overrun();
        test_full_pop_push();
        test_errors();
        test_dual_event();
        test_threshold();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
